ip_1port_ram_rw: RTL and testbench



---
 rtl/ip_ram_pkg.sv | 13 +
 rtl/spram_sync.sv | 44 ++++
 rtl/ip_1port_ram_rw.sv | 84 ++++++++
 tb/tb_ip_1port_ram_rw.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ip_ram_pkg.sv
// Shared defaults for the single-port RAM bring-up block.
//   AddrW    - RAM address width
//   DataW    - RAM data width
//   Depth    - number of RAM words (2**AddrW)
//   PhaseLen - cycles spent in each of the write and read phases
package ip_ram_pkg;

  localparam int unsigned AddrW    = 5;
  localparam int unsigned DataW    = 8;
  localparam int unsigned Depth    = 32;
  localparam int unsigned PhaseLen = Depth;

endpackage

// File: rtl/spram_sync.sv
// Generic single-port synchronous RAM, write-no-change read mode.
//   sys_clk   - clock, all activity on posedge
//   sys_rst_n - synchronous active-low reset, clears douta only (array is not reset)
//   ena       - port enable
//   wea       - 1 = write dina to mem[addra], 0 = read mem[addra]
//   addra     - word address
//   dina      - write data
//   douta     - read data, valid one cycle after a read is presented
module spram_sync #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] douta_q;

  // Array is kept out of reset so its contents survive a controller restart.
  always_ff @(posedge sys_clk) begin
    if (ena && wea) begin
      mem[addra] <= dina;
    end
  end

  // douta holds on writes and when disabled (no write-through).
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      douta_q <= '0;
    end else if (ena && !wea) begin
      douta_q <= mem[addra];
    end
  end

  assign douta = douta_q;

endmodule

// File: rtl/ip_1port_ram_rw.sv
// Self-stimulating write/read controller around a single-port RAM.
// After reset it writes addr->addr to every word, then reads every word back,
// repeating forever with a period of 2*DEPTH cycles.
//   sys_clk   - system clock
//   sys_rst_n - synchronous active-low reset
//   ena       - RAM port enable (registered)
//   wea       - RAM write enable, 1 during the write phase (registered)
//   addra     - RAM address (registered)
//   dina      - RAM write data, zero during reads (registered)
//   douta     - RAM read data
module ip_1port_ram_rw
  import ip_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned DEPTH  = Depth
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta
);

  if (DEPTH != (2 ** ADDR_W)) begin : g_bad_depth
    $error("DEPTH must equal 2**ADDR_W");
  end

  // One extra bit over the address: MSB clear = write phase, set = read phase.
  logic [ADDR_W:0]   rw_cnt_q, rw_cnt_d;
  logic              ena_q, ena_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;

  always_comb begin
    rw_cnt_d = rw_cnt_q + 1'b1;
    ena_d    = 1'b1;
    wea_d    = ~rw_cnt_q[ADDR_W];
    addra_d  = rw_cnt_q[ADDR_W-1:0];
    dina_d   = '0;
    if (wea_d) begin
      dina_d = DATA_W'(rw_cnt_q[ADDR_W-1:0]);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rw_cnt_q <= '0;
      ena_q    <= 1'b0;
      wea_q    <= 1'b0;
      addra_q  <= '0;
      dina_q   <= '0;
    end else begin
      rw_cnt_q <= rw_cnt_d;
      ena_q    <= ena_d;
      wea_q    <= wea_d;
      addra_q  <= addra_d;
      dina_q   <= dina_d;
    end
  end

  assign ena   = ena_q;
  assign wea   = wea_q;
  assign addra = addra_q;
  assign dina  = dina_q;

  spram_sync #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .ena      (ena_q),
    .wea      (wea_q),
    .addra    (addra_q),
    .dina     (dina_q),
    .douta    (douta)
  );

endmodule

// File: tb/tb_ip_1port_ram_rw.sv
module tb_ip_1port_ram_rw;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       ena;
  logic       wea;
  logic [4:0] addra;
  logic [7:0] dina;
  logic [7:0] douta;

  typedef struct {
    logic       ena;
    logic       wea;
    logic [4:0] addra;
    logic [7:0] dina;
    logic [7:0] douta;
    bit         chk_douta;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit stim_done = 1'b0;

  ip_1port_ram_rw u_dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .ena      (ena),
    .wea      (wea),
    .addra    (addra),
    .dina     (dina),
    .douta    (douta)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // Expected-sequence state, independent of the DUT.
  int         cyc;          // position in the 64-cycle sequence
  bit         prev_read;    // previous cycle presented a read
  logic [4:0] prev_addr;
  logic [7:0] douta_m;
  bit         pass_done;    // a full write pass has completed

  task automatic step(input logic rst_n);
    exp_t e;
    sys_rst_n = rst_n;
    @(posedge sys_clk);
    #1;
    if (!rst_n) begin
      e = '{ena: 1'b0, wea: 1'b0, addra: 5'd0, dina: 8'd0, douta: 8'd0, chk_douta: 1'b1};
      douta_m   = 8'd0;
      prev_read = 1'b0;
      cyc       = 0;
    end else begin
      // Read presented last cycle returns its address now; writes hold douta.
      if (prev_read) douta_m = {3'b000, prev_addr};
      e.ena       = 1'b1;
      e.wea       = (cyc < 32);
      e.addra     = 5'(cyc % 32);
      e.dina      = e.wea ? {3'b000, e.addra} : 8'd0;
      e.douta     = douta_m;
      e.chk_douta = pass_done;
      if (e.wea && e.addra == 5'd31) pass_done = 1'b1;
      prev_read = !e.wea;
      prev_addr = e.addra;
      cyc       = (cyc + 1) % 64;
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ena",   int'(ena),   int'(e.ena));
        chk("wea",   int'(wea),   int'(e.wea));
        chk("addra", int'(addra), int'(e.addra));
        chk("dina",  int'(dina),  int'(e.dina));
        if (e.chk_douta) chk("douta", int'(douta), int'(e.douta));
      end
    end
  end

  initial begin
    sys_rst_n = 1'b0;
    cyc       = 0;
    prev_read = 1'b0;
    prev_addr = '0;
    douta_m   = '0;
    pass_done = 1'b0;
    // Reset hold: 5 edges.
    for (int i = 0; i < 5; i++) step(1'b0);
    #9;  // release at 100 ns
    // Two full write/read periods, covering phase switch and wrap.
    for (int i = 0; i < 128; i++) step(1'b1);
    // Run into the read phase up to addra=10.
    for (int i = 0; i < 43; i++) step(1'b1);
    // Mid-run reset for one edge, then restart and read back again.
    step(1'b0);
    for (int i = 0; i < 80; i++) step(1'b1);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge sys_clk);
      budget++;
    end
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
